// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port 64-word data memory between the pipeline MEM stage (P)
//   and the program/data loader (L). At most one access is issued per cycle. Each
//   read is tagged so that its data, which returns one cycle later, reaches the
//   requester that issued it.
//
//   Optional feature: define DMEM_STARVE_GUARD_EN to add the loader starvation
//   guard. Once L has waited STARVE_MAX consecutive cycles, it wins the port in
//   IDLE for one cycle. Without the macro, P has strict priority in IDLE.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   p_req/p_we/p_addr/p_wdata   pipeline access request
//   p_flush                     kills this cycle's P request and the P read in flight
//   p_gnt, p_stall              P issued / P held off (combinational)
//   p_rvalid, p_rdata           P read response (driven from the registered tag)
//   l_req/l_we/l_lock/l_addr/l_wdata  loader request; l_lock keeps the port (burst)
//   l_gnt                       L issued (combinational)
//   l_rvalid, l_rdata           L read response (driven from the registered tag)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port, 1-cycle read latency
module dmem_port_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
`ifdef DMEM_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_MAX = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              p_flush,
  output logic              p_gnt,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, L_LOCK = 1'b1} state_t;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_P = 2'd1, TAG_L = 2'd2} tag_t;

  state_t            state_q, state_d;
  tag_t              tag_q, tag_d;
  logic              pv;
  logic              starve_force;
  logic [DATA_W-1:0] p_hold_q, l_hold_q;

  // A flushed P request is treated as absent.
  assign pv = p_req & ~p_flush;

`ifdef DMEM_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt_q;

  // Count consecutive cycles in which L waits. The count saturates at STARVE_MAX.
  assign starve_force = (starve_cnt_q == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (!l_req || l_gnt) begin
      starve_cnt_q <= '0;
    end else if (!starve_force) begin
      starve_cnt_q <= starve_cnt_q + CNT_W'(1);
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Grant decision and next state. No access is issued while reset is held.
  always_comb begin
    state_d = state_q;
    p_gnt   = 1'b0;
    l_gnt   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (l_req && (starve_force || !pv)) begin
            l_gnt = 1'b1;
            if (l_lock) state_d = L_LOCK;
          end else if (pv) begin
            p_gnt = 1'b1;
          end
        end
        L_LOCK: begin
          // P is held off for the whole burst, including the cycle in which L releases the port.
          l_gnt = l_req;
          if (!l_req || !l_lock) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Memory port mux. The port is parked at zero when no access is issued.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p_gnt) begin
      mem_we    = p_we;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else if (l_gnt) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  assign mem_en  = p_gnt | l_gnt;
  assign p_stall = p_req & ~p_gnt & ~rst;

  // Tag the read issued this cycle so its data is routed next cycle.
  always_comb begin
    tag_d = TAG_NONE;
    if (p_gnt && !p_we) begin
      tag_d = TAG_P;
    end else if (l_gnt && !l_we) begin
      tag_d = TAG_L;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= TAG_NONE;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  // Read data arrives in the cycle after issue. A flush in that cycle drops the P response.
  assign p_rvalid = (tag_q == TAG_P) & ~p_flush;
  assign l_rvalid = (tag_q == TAG_L);
  assign p_rdata  = p_rvalid ? mem_rdata : p_hold_q;
  assign l_rdata  = l_rvalid ? mem_rdata : l_hold_q;

  // Keep the last delivered word visible while no response is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_hold_q <= '0;
      l_hold_q <= '0;
    end else begin
      if (p_rvalid) p_hold_q <= mem_rdata;
      if (l_rvalid) l_hold_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: a table of per-cycle vectors, followed by a starvation sequence.
module tb_dmem_port_arbiter;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;
`ifdef DMEM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        p_req;
    logic        p_we;
    logic [5:0]  p_addr;
    logic [15:0] p_wdata;
    logic        p_flush;
    logic        l_req;
    logic        l_we;
    logic        l_lock;
    logic [5:0]  l_addr;
    logic [15:0] l_wdata;
  } in_t;

  typedef struct packed {
    logic        p_gnt;
    logic        l_gnt;
    logic        p_stall;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        p_rvalid;
    logic [15:0] p_rdata;
    logic        l_rvalid;
    logic [15:0] l_rdata;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, p_req, p_we, p_flush, l_req, l_we, l_lock;
  logic [5:0]  p_addr, l_addr, mem_addr;
  logic [15:0] p_wdata, l_wdata, mem_wdata, mem_rdata, p_rdata, l_rdata;
  logic        p_gnt, p_stall, p_rvalid, l_gnt, l_rvalid, mem_en, mem_we;
  logic        init;
  logic [15:0] mem [64];

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_flush(p_flush),
    .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, preloaded with 16'hA000 | address.
  always @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < 64; k++) mem[k] <= 16'hA000 | 16'(k);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  function automatic in_t pin(bit r, bit pq, bit pw, logic [5:0] pa, logic [15:0] pd, bit pf,
                              bit lq, bit lw, bit ll, logic [5:0] la, logic [15:0] ld);
    in_t v;
    v.rst = r; v.p_req = pq; v.p_we = pw; v.p_addr = pa; v.p_wdata = pd; v.p_flush = pf;
    v.l_req = lq; v.l_we = lw; v.l_lock = ll; v.l_addr = la; v.l_wdata = ld;
    return v;
  endfunction

  function automatic exp_t ex(bit pg, bit lg, bit st, bit en, bit we, logic [5:0] a, logic [15:0] wd,
                              bit prv, logic [15:0] prd, bit lrv, logic [15:0] lrd);
    exp_t v;
    v.p_gnt = pg; v.l_gnt = lg; v.p_stall = st; v.mem_en = en; v.mem_we = we;
    v.mem_addr = a; v.mem_wdata = wd; v.p_rvalid = prv; v.p_rdata = prd;
    v.l_rvalid = lrv; v.l_rdata = lrd;
    return v;
  endfunction

  task automatic add(input string n, input in_t i, input exp_t e);
    vec_t v;
    v.name = n; v.i = i; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic apply(input in_t i);
    rst = i.rst; p_req = i.p_req; p_we = i.p_we; p_addr = i.p_addr; p_wdata = i.p_wdata;
    p_flush = i.p_flush; l_req = i.l_req; l_we = i.l_we; l_lock = i.l_lock;
    l_addr = i.l_addr; l_wdata = i.l_wdata;
  endtask

  task automatic check(input string n, input exp_t e);
    exp_t a;
    a = {p_gnt, l_gnt, p_stall, mem_en, mem_we, mem_addr, mem_wdata,
         p_rvalid, p_rdata, l_rvalid, l_rdata};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got pg=%b lg=%b st=%b en=%b we=%b a=%0d wd=%h prv=%b prd=%h lrv=%b lrd=%h exp pg=%b lg=%b st=%b en=%b we=%b a=%0d wd=%h prv=%b prd=%h lrv=%b lrd=%h",
               n, a.p_gnt, a.l_gnt, a.p_stall, a.mem_en, a.mem_we, a.mem_addr, a.mem_wdata,
               a.p_rvalid, a.p_rdata, a.l_rvalid, a.l_rdata,
               e.p_gnt, e.l_gnt, e.p_stall, e.mem_en, e.mem_we, e.mem_addr, e.mem_wdata,
               e.p_rvalid, e.p_rdata, e.l_rvalid, e.l_rdata);
    end
  endtask

  initial begin
    init = 1'b1;
    apply(pin(Y,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0));
    repeat (2) @(posedge clk);
    #1 init = 1'b0;

    // Reset, including reset held with requests active.
    add("rst_idle",    pin(Y,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),  ex(N,N,N,N,N,6'd0,16'h0,N,16'h0,N,16'h0));
    add("rst_traffic", pin(Y,Y,N,6'd5,16'h0,N,Y,N,N,6'd2,16'h0),  ex(N,N,N,N,N,6'd0,16'h0,N,16'h0,N,16'h0));
    add("t1_p_rd5",    pin(N,Y,N,6'd5,16'h0,N,N,N,N,6'd0,16'h0),  ex(Y,N,N,Y,N,6'd5,16'h0,N,16'h0,N,16'h0));
    add("t1_p_rv",     pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),  ex(N,N,N,N,N,6'd0,16'h0,Y,16'hA005,N,16'h0));
    // Contention: P wins, then L is granted.
    add("t2_contend",  pin(N,Y,N,6'd1,16'h0,N,Y,N,N,6'd2,16'h0),  ex(Y,N,N,Y,N,6'd1,16'h0,N,16'hA005,N,16'h0));
    add("t2_l_after",  pin(N,N,N,6'd0,16'h0,N,Y,N,N,6'd2,16'h0),  ex(N,Y,N,Y,N,6'd2,16'h0,Y,16'hA001,N,16'h0));
    add("t2_l_rv",     pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),  ex(N,N,N,N,N,6'd0,16'h0,N,16'hA001,Y,16'hA002));
    // Burst of L writes to addresses 10..13; P is held off until the burst ends.
    add("t3_b0",       pin(N,N,N,6'd0,16'h0,N,Y,Y,Y,6'd10,16'h5A0A),  ex(N,Y,N,Y,Y,6'd10,16'h5A0A,N,16'hA001,N,16'hA002));
    add("t3_b1",       pin(N,Y,N,6'd10,16'h0,N,Y,Y,Y,6'd11,16'h5A0B), ex(N,Y,Y,Y,Y,6'd11,16'h5A0B,N,16'hA001,N,16'hA002));
    add("t3_b2",       pin(N,Y,N,6'd10,16'h0,N,Y,Y,Y,6'd12,16'h5A0C), ex(N,Y,Y,Y,Y,6'd12,16'h5A0C,N,16'hA001,N,16'hA002));
    add("t3_b3",       pin(N,Y,N,6'd10,16'h0,N,Y,Y,N,6'd13,16'h5A0D), ex(N,Y,Y,Y,Y,6'd13,16'h5A0D,N,16'hA001,N,16'hA002));
    add("t3_p_go",     pin(N,Y,N,6'd10,16'h0,N,N,N,N,6'd0,16'h0),  ex(Y,N,N,Y,N,6'd10,16'h0,N,16'hA001,N,16'hA002));
    add("t3_rd10",     pin(N,Y,N,6'd13,16'h0,N,N,N,N,6'd0,16'h0),  ex(Y,N,N,Y,N,6'd13,16'h0,Y,16'h5A0A,N,16'hA002));
    add("t3_rd13",     pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),   ex(N,N,N,N,N,6'd0,16'h0,Y,16'h5A0D,N,16'hA002));
    // Flush drops the in-flight P read and kills the P request in the same cycle.
    add("t4_p_rd7",    pin(N,Y,N,6'd7,16'h0,N,N,N,N,6'd0,16'h0),   ex(Y,N,N,Y,N,6'd7,16'h0,N,16'h5A0D,N,16'hA002));
    add("t4_flush",    pin(N,Y,N,6'd8,16'h0,Y,N,N,N,6'd0,16'h0),   ex(N,N,Y,N,N,6'd0,16'h0,N,16'h5A0D,N,16'hA002));
    add("t4_after",    pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),   ex(N,N,N,N,N,6'd0,16'h0,N,16'h5A0D,N,16'hA002));
    add("fl_l_rd9",    pin(N,N,N,6'd0,16'h0,Y,Y,N,N,6'd9,16'h0),   ex(N,Y,N,Y,N,6'd9,16'h0,N,16'h5A0D,N,16'hA002));
    add("fl_l_rv",     pin(N,N,N,6'd0,16'h0,Y,N,N,N,6'd0,16'h0),   ex(N,N,N,N,N,6'd0,16'h0,N,16'h5A0D,Y,16'hA009));
    // Each response goes to the requester whose read was issued the cycle before.
    add("t6_l_rd3",    pin(N,N,N,6'd0,16'h0,N,Y,N,N,6'd3,16'h0),   ex(N,Y,N,Y,N,6'd3,16'h0,N,16'h5A0D,N,16'hA009));
    add("t6_p_rd4",    pin(N,Y,N,6'd4,16'h0,N,N,N,N,6'd0,16'h0),   ex(Y,N,N,Y,N,6'd4,16'h0,N,16'h5A0D,Y,16'hA003));
    add("t6_p_rv",     pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),   ex(N,N,N,N,N,6'd0,16'h0,Y,16'hA004,N,16'hA003));
    // Reset in the middle of a locked burst discards the pending read and returns to IDLE.
    add("rb_l_rd6",    pin(N,N,N,6'd0,16'h0,N,Y,N,Y,6'd6,16'h0),   ex(N,Y,N,Y,N,6'd6,16'h0,N,16'hA004,N,16'hA003));
    add("rb_rst",      pin(Y,Y,N,6'd5,16'h0,N,Y,N,Y,6'd6,16'h0),   ex(N,N,N,N,N,6'd0,16'h0,N,16'h0,N,16'h0));
    add("rb_release",  pin(N,Y,N,6'd5,16'h0,N,Y,N,Y,6'd6,16'h0),   ex(Y,N,N,Y,N,6'd5,16'h0,N,16'h0,N,16'h0));
    add("rb_rv",       pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),   ex(N,N,N,N,N,6'd0,16'h0,Y,16'hA005,N,16'h0));
    // L drops its request mid-lock: no grant that cycle, then P is served.
    add("lk_l_wr30",   pin(N,N,N,6'd0,16'h0,N,Y,Y,Y,6'd30,16'h1234), ex(N,Y,N,Y,Y,6'd30,16'h1234,N,16'hA005,N,16'h0));
    add("lk_drop",     pin(N,Y,N,6'd30,16'h0,N,N,N,N,6'd0,16'h0),  ex(N,N,Y,N,N,6'd0,16'h0,N,16'hA005,N,16'h0));
    add("lk_p_rd30",   pin(N,Y,N,6'd30,16'h0,N,N,N,N,6'd0,16'h0),  ex(Y,N,N,Y,N,6'd30,16'h0,N,16'hA005,N,16'h0));
    add("lk_p_rv",     pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),   ex(N,N,N,N,N,6'd0,16'h0,Y,16'h1234,N,16'h0));
    // A P write produces no response; read it back afterwards.
    add("p_wr40",      pin(N,Y,Y,6'd40,16'hBEEF,N,N,N,N,6'd0,16'h0), ex(Y,N,N,Y,Y,6'd40,16'hBEEF,N,16'h1234,N,16'h0));
    add("p_rd40",      pin(N,Y,N,6'd40,16'h0,N,N,N,N,6'd0,16'h0),  ex(Y,N,N,Y,N,6'd40,16'h0,N,16'h1234,N,16'h0));
    add("p_rv40",      pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0),   ex(N,N,N,N,N,6'd0,16'h0,Y,16'hBEEF,N,16'h0));

    foreach (vecs[n]) begin
      @(posedge clk);
      #1 apply(vecs[n].i);
      @(negedge clk);
      check(vecs[n].name, vecs[n].e);
    end

    // Starvation: both requesters held high. The guard hands cycle 5 to L.
    for (int k = 1; k <= 8; k++) begin
      bit lw;
      lw = GUARD && (k == 5);
      @(posedge clk);
      #1 apply(pin(N,Y,N,6'd50,16'h0,N,Y,N,N,6'd51,16'h0));
      @(negedge clk);
      checks++;
      if ({p_gnt, l_gnt, p_stall, mem_addr} !== {!lw, lw, lw, lw ? 6'd51 : 6'd50}) begin
        errors++;
        $display("FAIL starve_c%0d got pg=%b lg=%b st=%b a=%0d exp pg=%b lg=%b st=%b a=%0d",
                 k, p_gnt, l_gnt, p_stall, mem_addr, !lw, lw, lw, lw ? 6'd51 : 6'd50);
      end
    end
    @(posedge clk);
    #1 apply(pin(N,N,N,6'd0,16'h0,N,N,N,N,6'd0,16'h0));
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
